// File: rtl/abus_slave.sv
// Responder end of the abus handshake: decodes requests in its address window and turns
// each into one strobed local register access, with wait states, abort and timeout.
module abus_slave #(
  parameter int unsigned                ADDR_WIDTH   = 16,
  parameter int unsigned                DATA_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR    = '0,
  parameter int unsigned                WINDOW_BITS  = 8,
  parameter int unsigned                MAX_WAIT     = 15,
  parameter logic [DATA_WIDTH-1:0]      TIMEOUT_DATA = '1
) (
  input  logic                   abus_clk,
  input  logic                   abus_rstb,
  input  logic                   abus_sreq,
  input  logic [2:0]             abus_smid,
  input  logic                   abus_swrite,
  input  logic                   abus_sread,
  input  logic                   abus_sabort,
  input  logic [ADDR_WIDTH-1:0]  abus_saddress,
  input  logic [DATA_WIDTH-1:0]  abus_swdata,
  output logic                   abus_sack,
  output logic [DATA_WIDTH-1:0]  abus_srdata,
  output logic                   reg_wen,
  output logic                   reg_ren,
  output logic [WINDOW_BITS-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]  reg_wdata,
  input  logic [DATA_WIDTH-1:0]  reg_rdata,
  input  logic                   reg_ready,
  output logic [2:0]             owner_mid,
  output logic                   timeout
);

  localparam int unsigned      CntW   = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]  CntMax = CntW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StAck, StAbort} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         wait_cnt_q;
  logic                    is_read_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    hit;
  logic                    cnt_max;

  assign hit = abus_sreq &&
               (abus_saddress[ADDR_WIDTH-1:WINDOW_BITS] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_BITS]);
  assign cnt_max = (wait_cnt_q == CntMax);

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      is_read_q   <= 1'b0;
      rdata_q     <= '0;
      abus_sack   <= 1'b0;
      abus_srdata <= '0;
      reg_wen     <= 1'b0;
      reg_ren     <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      owner_mid   <= '0;
      timeout     <= 1'b0;
    end else begin
      reg_wen     <= 1'b0;
      reg_ren     <= 1'b0;
      timeout     <= 1'b0;
      abus_sack   <= 1'b0;
      abus_srdata <= '0;
      case (state_q)
        StIdle: begin
          if (hit && abus_sabort) begin
            // Stray abort: acknowledge with zero data, nothing reaches the register bank
            state_q <= StAck;
            rdata_q <= '0;
          end else if (hit && (abus_swrite ^ abus_sread)) begin
            state_q    <= StAccess;
            reg_addr   <= abus_saddress[WINDOW_BITS-1:0];
            reg_wdata  <= abus_swdata;
            owner_mid  <= abus_smid;
            reg_wen    <= abus_swrite;
            reg_ren    <= abus_sread;
            is_read_q  <= abus_sread;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
          end
        end
        StAccess: begin
          if (reg_ready) begin
            state_q <= StAck;
            if (is_read_q) rdata_q <= reg_rdata;
          end else if (abus_sabort) begin
            // The local access is already issued; drain it before acking with zero data
            state_q <= StAbort;
          end else if (cnt_max) begin
            state_q <= StAck;
            timeout <= 1'b1;
            if (is_read_q) rdata_q <= TIMEOUT_DATA;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StAbort: begin
          rdata_q <= '0;
          if (reg_ready) begin
            state_q <= StAck;
          end else if (cnt_max) begin
            state_q <= StAck;
            timeout <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StAck: begin
          if (abus_sreq) begin
            abus_sack   <= 1'b1;
            abus_srdata <= rdata_q;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_abus_slave.sv
// Scoreboard bench for abus_slave: expected strobes and acks are queued as requests are
// driven and matched by a monitor when the DUT produces them.
module tb_abus_slave;

  localparam int          MaxWait = 15;
  localparam logic [15:0] Base    = 16'h4200;

  logic        abus_clk = 1'b0;
  logic        abus_rstb;
  logic        abus_sreq = 1'b0;
  logic [2:0]  abus_smid = '0;
  logic        abus_swrite = 1'b0;
  logic        abus_sread = 1'b0;
  logic        abus_sabort = 1'b0;
  logic [15:0] abus_saddress = '0;
  logic [15:0] abus_swdata = '0;
  logic        abus_sack;
  logic [15:0] abus_srdata;
  logic        reg_wen;
  logic        reg_ren;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = '0;
  logic        reg_ready = 1'b0;
  logic [2:0]  owner_mid;
  logic        timeout;

  always #5 abus_clk = ~abus_clk;

  abus_slave #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (16),
    .BASE_ADDR    (Base),
    .WINDOW_BITS  (8),
    .MAX_WAIT     (MaxWait),
    .TIMEOUT_DATA (16'hFFFF)
  ) dut (
    .abus_clk      (abus_clk),
    .abus_rstb     (abus_rstb),
    .abus_sreq     (abus_sreq),
    .abus_smid     (abus_smid),
    .abus_swrite   (abus_swrite),
    .abus_sread    (abus_sread),
    .abus_sabort   (abus_sabort),
    .abus_saddress (abus_saddress),
    .abus_swdata   (abus_swdata),
    .abus_sack     (abus_sack),
    .abus_srdata   (abus_srdata),
    .reg_wen       (reg_wen),
    .reg_ren       (reg_ren),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .reg_ready     (reg_ready),
    .owner_mid     (owner_mid),
    .timeout       (timeout)
  );

  typedef struct packed {logic [15:0] data; logic [2:0] mid;} ack_t;
  typedef struct packed {logic wen; logic ren; logic [7:0] addr; logic [15:0] wdata;} strb_t;

  ack_t  ack_q[$];
  strb_t strb_q[$];
  ack_t  ae;
  strb_t se;
  int    total = 0;
  int    bad = 0;
  int    tmo_cnt = 0;
  int    strobe_cnt = 0;
  logic  prev_sack = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge abus_clk);
    #1;
  endtask

  // Monitor: match strobes and ack rising edges against the scoreboard
  always @(negedge abus_clk) begin
    if (reg_wen === 1'b1 || reg_ren === 1'b1) begin
      strobe_cnt++;
      if (strb_q.size() == 0) begin
        check("strobe_unexpected", 1, 0);
      end else begin
        se = strb_q.pop_front();
        check("strobe", {reg_wen, reg_ren, reg_addr, reg_wdata}, se);
      end
    end
    if (timeout === 1'b1) tmo_cnt++;
    if (abus_sack === 1'b1 && !prev_sack) begin
      if (ack_q.size() == 0) begin
        check("sack_unexpected", 1, 0);
      end else begin
        ae = ack_q.pop_front();
        check("ack_data_mid", {abus_srdata, owner_mid}, ae);
      end
    end
    prev_sack <= (abus_sack === 1'b1);
  end

  task automatic clear_bus();
    abus_sreq   = 1'b0;
    abus_swrite = 1'b0;
    abus_sread  = 1'b0;
    abus_sabort = 1'b0;
    reg_ready   = 1'b0;
  endtask

  // ready_lat: ACCESS-cycle index (0 = strobe cycle) at which reg_ready rises
  // abort_at: cycle index at which sabort rises, or -1 for none
  task automatic run_txn(input string tag, input logic wr, input logic rd, input logic [2:0] mid,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int ready_lat, input int abort_at,
                         input bit rst_in_ack);
    int   e;
    bit   exp_tmo;
    bit   saw;
    int   t0_tmo;
    int   t0_str;
    logic [15:0] exp_data;
    exp_tmo = (ready_lat > MaxWait);
    e = exp_tmo ? MaxWait : ready_lat;
    if (abort_at >= 0)  exp_data = 16'h0;
    else if (rd)        exp_data = exp_tmo ? 16'hFFFF : rdata;
    else                exp_data = 16'h0;
    ack_q.push_back({exp_data, mid});
    strb_q.push_back({wr, rd, addr[7:0], wdata});
    t0_tmo = tmo_cnt;
    t0_str = strobe_cnt;
    abus_sreq     = 1'b1;
    abus_smid     = mid;
    abus_swrite   = wr;
    abus_sread    = rd;
    abus_saddress = addr;
    abus_swdata   = wdata;
    reg_rdata     = rdata;
    reg_ready     = 1'b0;
    saw = 0;
    for (int k = 1; k <= MaxWait + 10 && !saw; k++) begin
      tick();
      reg_ready   = (k - 1 >= ready_lat);
      abus_sabort = (abort_at >= 0) && (k - 1 >= abort_at);
      if (abus_sack === 1'b1) begin
        saw = 1;
        check({tag, "_latency"}, k, e + 3);
      end
    end
    if (!saw) check({tag, "_no_sack"}, 0, 1);
    tick();
    check({tag, "_held"}, {abus_sack, abus_srdata}, {1'b1, exp_data});
    if (rst_in_ack) begin
      abus_rstb = 1'b0;
      #1;
      check({tag, "_async_rst"}, {abus_sack, abus_srdata, owner_mid, reg_wen, reg_ren}, 0);
      clear_bus();
      #1;
      abus_rstb = 1'b1;
      tick();
    end else begin
      clear_bus();
      tick();
      check({tag, "_drop"}, {abus_sack, abus_srdata}, 0);
    end
    tick();
    check({tag, "_strobe_cnt"}, strobe_cnt - t0_str, 1);
    check({tag, "_timeout_cnt"}, tmo_cnt - t0_tmo, exp_tmo ? 1 : 0);
  endtask

  task automatic no_hit(input string tag, input logic [15:0] addr, input logic wr,
                        input logic rd);
    int t0_str;
    int acks;
    t0_str = strobe_cnt;
    acks = 0;
    abus_sreq     = 1'b1;
    abus_swrite   = wr;
    abus_sread    = rd;
    abus_saddress = addr;
    reg_ready     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (abus_sack !== 1'b0) acks++;
    end
    clear_bus();
    tick();
    check({tag, "_sack"}, acks, 0);
    check({tag, "_strobe_cnt"}, strobe_cnt - t0_str, 0);
  endtask

  task automatic stray_abort(input logic [2:0] last_mid);
    int  t0_str;
    bit  saw;
    t0_str = strobe_cnt;
    ack_q.push_back({16'h0, last_mid});
    abus_sreq     = 1'b1;
    abus_sabort   = 1'b1;
    abus_smid     = 3'd6;
    abus_saddress = Base + 16'd5;
    saw = 0;
    for (int k = 1; k <= 6 && !saw; k++) begin
      tick();
      if (abus_sack === 1'b1) begin
        saw = 1;
        check("stray_abort_latency", k, 2);
      end
    end
    if (!saw) check("stray_abort_no_sack", 0, 1);
    clear_bus();
    tick();
    check("stray_abort_drop", abus_sack, 0);
    check("stray_abort_strobe_cnt", strobe_cnt - t0_str, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    abus_rstb = 1'b1;
    #2;
    abus_rstb = 1'b0;
    #20;
    check("reset_outputs",
          {abus_sack, abus_srdata, reg_wen, reg_ren, owner_mid, timeout}, 0);
    check("reset_reg_bus", {reg_addr, reg_wdata}, 0);
    abus_rstb = 1'b1;
    tick();

    run_txn("wr",     1'b1, 1'b0, 3'd1, Base + 16'd3,    16'hA5A5, 16'h0,    0,    -1, 0);
    stray_abort(3'd1);
    run_txn("rd",     1'b0, 1'b1, 3'd2, Base + 16'd7,    16'h0,    16'h1234, 3,    -1, 0);
    run_txn("rd_max", 1'b0, 1'b1, 3'd2, Base + 16'd1,    16'h0,    16'h2468, 15,   -1, 0);
    run_txn("tmo",    1'b0, 1'b1, 3'd3, Base + 16'd9,    16'h0,    16'h5555, 1000, -1, 0);
    run_txn("abt_wr", 1'b1, 1'b0, 3'd4, Base + 16'h20,   16'hBEEF, 16'h0,    6,    2,  0);
    run_txn("abt_rd", 1'b0, 1'b1, 3'd6, Base + 16'h11,   16'h0,    16'h7777, 5,    1,  0);
    no_hit("out_hi",  16'h4303, 1'b1, 1'b0);
    no_hit("out_lo",  16'h0203, 1'b0, 1'b1);
    no_hit("both",    Base + 16'd3, 1'b1, 1'b1);
    no_hit("neither", Base + 16'd3, 1'b0, 1'b0);
    run_txn("rst",    1'b0, 1'b1, 3'd5, Base + 16'hFF,   16'h0,    16'h0F0F, 0,    -1, 1);
    run_txn("after",  1'b1, 1'b0, 3'd7, Base + 16'h40,   16'h1357, 16'h0,    2,    -1, 0);

    check("ack_queue_empty", ack_q.size(), 0);
    check("strobe_queue_empty", strb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
